// File: rtl/hx8352_reg_reader.sv
// -----------------------------------------------------------------------------
// hx8352_reg_reader
//
// Read-side companion to the HX8352 LCD write controller. Runs one 8080-style
// read transaction per accepted request: an index write (RS=0, WR strobe),
// a bus turnaround, then one or more RD strobes (RS=1). It returns each
// sampled 16-bit word with a one-cycle rd_valid pulse. When dummy_read is
// set, the first RD strobe is discarded, as GRAM reads require. The top
// level owns the shared lcd_* pins and the tristate data bus. data_oe tells
// it when to drive data_out.
//
// Ports
//   clk, rst        system clock (50 MHz); asynchronous active-high reset
//   req             start request, sampled only while idle
//   index           register index sent during the RS=0 write phase
//   rd_len          words to read minus one (0..255 -> 1..256 words)
//   dummy_read      discard the first RD strobe
//   busy            transaction in progress
//   rd_data         most recent sampled word
//   rd_valid        one-cycle pulse when rd_data holds a new word
//   lcd_cs          chip select, active-low
//   lcd_rs          0 = index cycle, 1 = data cycle
//   lcd_wr          write strobe, active-low
//   lcd_rd          read strobe, active-low
//   data_out        value driven onto the bus while data_oe=1
//   data_oe         bus drive enable for the top level
//   data_in         bus read value, sampled directly (pad-synchronous)
// -----------------------------------------------------------------------------
module hx8352_reg_reader #(
  parameter int WR_LOW  = 3,
  parameter int WR_HIGH = 3,
  parameter int TURN    = 2,
  parameter int RD_LOW  = 8,
  parameter int RD_HIGH = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [15:0] index,
  input  logic [7:0]  rd_len,
  input  logic        dummy_read,
  output logic        busy,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        lcd_cs,
  output logic        lcd_rs,
  output logic        lcd_wr,
  output logic        lcd_rd,
  output logic [15:0] data_out,
  output logic        data_oe,
  input  logic [15:0] data_in
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_IDX_WRL,
    S_IDX_WRH,
    S_TURN,
    S_RD_L,
    S_RD_H
  } state_t;

  // Phase counter width: every phase length must fit in 8 bits.
  localparam int CNT_W = 8;

  // A phase counter is loaded with (length - 1). The phase ends on the
  // cycle where the counter reads zero.
  localparam logic [CNT_W-1:0] WR_LOW_M1  = CNT_W'(WR_LOW  - 1);
  localparam logic [CNT_W-1:0] WR_HIGH_M1 = CNT_W'(WR_HIGH - 1);
  localparam logic [CNT_W-1:0] TURN_M1    = CNT_W'(TURN    - 1);
  localparam logic [CNT_W-1:0] RD_LOW_M1  = CNT_W'(RD_LOW  - 1);
  localparam logic [CNT_W-1:0] RD_HIGH_M1 = CNT_W'(RD_HIGH - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  // Strobes still to run, including the current one. It can hold 257
  // (rd_len=255 plus a dummy strobe), so it needs 9 bits and never wraps.
  logic [8:0]        words_left_q, words_left_d;
  logic              dummy_pend_q, dummy_pend_d;

  logic [15:0]       rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic [15:0]       data_out_q, data_out_d;
  logic              busy_q, busy_d;
  logic              cs_q, cs_d;
  logic              rs_q, rs_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic              oe_q, oe_d;

  // Next-state logic. Outputs are decoded from state_d, so each registered
  // output changes on the same edge as the state it belongs to.
  always_comb begin
    // NOTE: every signal gets a default here, so no path through the case
    // leaves one unassigned and no latch is inferred.
    state_d      = state_q;
    cnt_d        = cnt_q;
    words_left_d = words_left_q;
    dummy_pend_d = dummy_pend_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = 1'b0;
    data_out_d   = data_out_q;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d      = S_IDX_WRL;
          cnt_d        = WR_LOW_M1;
          words_left_d = {1'b0, rd_len} + 9'd1 + {8'd0, dummy_read};
          dummy_pend_d = dummy_read;
          data_out_d   = index;
        end
      end

      S_IDX_WRL: begin
        if (cnt_q == '0) begin
          state_d = S_IDX_WRH;
          cnt_d   = WR_HIGH_M1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_IDX_WRH: begin
        if (cnt_q == '0) begin
          state_d = S_TURN;
          cnt_d   = TURN_M1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_TURN: begin
        if (cnt_q == '0) begin
          state_d = S_RD_L;
          cnt_d   = RD_LOW_M1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_RD_L: begin
        if (cnt_q == '0) begin
          state_d = S_RD_H;
          cnt_d   = RD_HIGH_M1;
          // Sample on the edge that ends the last RD-low cycle. The word then
          // appears, with rd_valid, in the first RD-high cycle. A dummy strobe
          // only clears its pending flag.
          if (dummy_pend_q) begin
            dummy_pend_d = 1'b0;
          end else begin
            rd_data_d  = data_in;
            rd_valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_RD_H: begin
        if (cnt_q == '0) begin
          if (words_left_q == 9'd1) begin
            state_d = S_IDLE;
          end else begin
            state_d      = S_RD_L;
            cnt_d        = RD_LOW_M1;
            words_left_d = words_left_q - 9'd1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Pin levels for the state being entered. WR and RD belong to different
    // states, so they can never both be low. OE drops before any RD phase.
    busy_d = (state_d != S_IDLE);
    cs_d   = (state_d == S_IDLE);
    rs_d   = !((state_d == S_IDX_WRL) || (state_d == S_IDX_WRH));
    wr_d   = (state_d != S_IDX_WRL);
    rd_d   = (state_d != S_RD_L);
    oe_d   = (state_d == S_IDX_WRL) || (state_d == S_IDX_WRH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      words_left_q <= '0;
      dummy_pend_q <= 1'b0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      data_out_q   <= '0;
      busy_q       <= 1'b0;
      cs_q         <= 1'b1;
      rs_q         <= 1'b1;
      wr_q         <= 1'b1;
      rd_q         <= 1'b1;
      oe_q         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every flop samples the values
      // from before this edge, regardless of statement order.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      words_left_q <= words_left_d;
      dummy_pend_q <= dummy_pend_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      data_out_q   <= data_out_d;
      busy_q       <= busy_d;
      cs_q         <= cs_d;
      rs_q         <= rs_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      oe_q         <= oe_d;
    end
  end

  assign busy     = busy_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign lcd_cs   = cs_q;
  assign lcd_rs   = rs_q;
  assign lcd_wr   = wr_q;
  assign lcd_rd   = rd_q;
  assign data_out = data_out_q;
  assign data_oe  = oe_q;

endmodule

// File: tb/tb_hx8352_reg_reader.sv
// -----------------------------------------------------------------------------
// tb_hx8352_reg_reader
//
// Directed and randomized bench for hx8352_reg_reader. For each transaction,
// the expected pin waveform is computed from its phase lengths with plain
// arithmetic on the cycle number after acceptance. Cycle k=1 is the first
// cycle after the accepting edge. Each read word is presented on data_in only
// in the last RD-low cycle, with random noise elsewhere. This exposes any
// sampling on the wrong edge.
// -----------------------------------------------------------------------------
module tb_hx8352_reg_reader;

  localparam int P_WR_LOW  = 3;
  localparam int P_WR_HIGH = 3;
  localparam int P_TURN    = 2;
  localparam int P_RD_LOW  = 8;
  localparam int P_RD_HIGH = 5;
  localparam int PRE       = P_WR_LOW + P_WR_HIGH + P_TURN;  // cycles before first RD
  localparam int STROBE    = P_RD_LOW + P_RD_HIGH;            // cycles per RD strobe

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [15:0] index;
  logic [7:0]  rd_len;
  logic        dummy_read;
  logic        busy;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        lcd_cs;
  logic        lcd_rs;
  logic        lcd_wr;
  logic        lcd_rd;
  logic [15:0] data_out;
  logic        data_oe;
  logic [15:0] data_in;

  int errors = 0;
  int checks = 0;

  logic [15:0] bus_words [0:257];
  logic [15:0] exp_rd_data;

  hx8352_reg_reader #(
    .WR_LOW (P_WR_LOW),
    .WR_HIGH(P_WR_HIGH),
    .TURN   (P_TURN),
    .RD_LOW (P_RD_LOW),
    .RD_HIGH(P_RD_HIGH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .index     (index),
    .rd_len    (rd_len),
    .dummy_read(dummy_read),
    .busy      (busy),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .lcd_cs    (lcd_cs),
    .lcd_rs    (lcd_rs),
    .lcd_wr    (lcd_wr),
    .lcd_rd    (lcd_rd),
    .data_out  (data_out),
    .data_oe   (data_oe),
    .data_in   (data_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pin invariants that must hold in every cycle.
  task automatic check_invariants();
    check("no_wr_rd_overlap", 32'(!(lcd_wr == 1'b0 && lcd_rd == 1'b0)), 32'd1);
    check("no_oe_during_rd",  32'(!(lcd_rd == 1'b0 && data_oe == 1'b1)), 32'd1);
    check("cs_high_when_idle", 32'(busy || lcd_cs), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cs"},       32'(lcd_cs),   32'd1);
    check({tag, "_rs"},       32'(lcd_rs),   32'd1);
    check({tag, "_wr"},       32'(lcd_wr),   32'd1);
    check({tag, "_rd"},       32'(lcd_rd),   32'd1);
    check({tag, "_oe"},       32'(data_oe),  32'd0);
    check({tag, "_data_out"}, 32'(data_out), 32'd0);
    check({tag, "_busy"},     32'(busy),     32'd0);
    check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    check({tag, "_rd_data"},  32'(rd_data),  32'd0);
  endtask

  // Idle cycles with req low: nothing may start and no word may appear.
  task automatic idle(input int n);
    req = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_busy",     32'(busy),     32'd0);
      check("idle_cs",       32'(lcd_cs),   32'd1);
      check("idle_rd_valid", 32'(rd_valid), 32'd0);
      check("idle_rd_data",  32'(rd_data),  32'(exp_rd_data));
      check_invariants();
      data_in = 16'($urandom);
    end
  endtask

  // Start at a negedge with the DUT idle. Request one transaction whose read
  // words come from bus_words[0..]. Check every cycle through the first idle
  // cycle (k = B+1), or stop after cycle stop_k-1 when stop_k > 0.
  task automatic run_txn(input logic [15:0] idx, input int len, input bit dum, input int stop_k);
    int strobes;
    int b;
    int last_k;
    int s;
    int ph;
    bit in_rd;
    bit exp_valid;
    strobes = len + 1 + int'(dum);
    b       = PRE + strobes * STROBE;
    last_k  = (stop_k > 0) ? stop_k - 1 : b + 1;

    req        = 1'b1;
    index      = idx;
    rd_len     = 8'(len);
    dummy_read = dum;

    for (int k = 1; k <= last_k; k++) begin
      @(negedge clk);
      in_rd     = (k > PRE) && (k <= b);
      s         = in_rd ? (k - PRE - 1) / STROBE : 0;
      ph        = in_rd ? (k - PRE - 1) % STROBE : 0;
      exp_valid = in_rd && (ph == P_RD_LOW) && (s >= int'(dum));
      if (exp_valid) exp_rd_data = bus_words[s];

      check("busy", 32'(busy),   32'(k <= b));
      check("cs",   32'(lcd_cs), 32'(k > b));
      check("wr",   32'(lcd_wr), 32'(k > P_WR_LOW));
      check("rs",   32'(lcd_rs), 32'(k > P_WR_LOW + P_WR_HIGH));
      check("oe",   32'(data_oe), 32'(k <= P_WR_LOW + P_WR_HIGH));
      if (k <= P_WR_LOW + P_WR_HIGH) check("data_out", 32'(data_out), 32'(idx));
      check("rd",       32'(lcd_rd),   32'(!(in_rd && ph < P_RD_LOW)));
      check("rd_valid", 32'(rd_valid), 32'(exp_valid));
      check("rd_data",  32'(rd_data),  32'(exp_rd_data));
      check_invariants();

      // Bus model: the word is valid only in the last RD-low cycle of its strobe.
      if (in_rd && ph == P_RD_LOW - 1) data_in = bus_words[s];
      else                             data_in = 16'($urandom);

      // Disturb the request inputs while busy; they must be ignored.
      if (k <= b) begin
        req        = 1'($urandom);
        index      = 16'($urandom);
        rd_len     = 8'($urandom);
        dummy_read = 1'($urandom);
      end else begin
        req = 1'b0;
      end
    end
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) bus_words[i] = 16'($urandom);
  endtask

  initial begin
    int len;
    bit dum;

    exp_rd_data = 16'h0000;
    rst         = 1'b1;
    req         = 1'b0;
    index       = 16'h0000;
    rd_len      = 8'd0;
    dummy_read  = 1'b0;
    data_in     = 16'h0000;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    idle(2);

    // Single word, no dummy
    bus_words[0] = 16'h5252;
    run_txn(16'h0000, 0, 1'b0, 0);
    idle(3);

    // Dummy read plus three words
    bus_words[0] = 16'hAAAA;
    bus_words[1] = 16'h1111;
    bus_words[2] = 16'h2222;
    bus_words[3] = 16'h3333;
    run_txn(16'h0022, 2, 1'b1, 0);

    // Back-to-back: each transaction starts on the first idle cycle after the last
    for (int t = 0; t < 6; t++) begin
      len = int'($urandom_range(0, 5));
      dum = 1'($urandom);
      fill_random(len + 2);
      run_txn(16'($urandom), len, dum, 0);
    end
    idle(2);

    // 256 words
    fill_random(256);
    run_txn(16'($urandom), 255, 1'b0, 0);
    idle(2);

    // Reset in the middle of RD-low of word 2 of 3
    fill_random(3);
    run_txn(16'h0004, 2, 1'b0, PRE + STROBE + 4);
    @(negedge clk);
    rst = 1'b1;
    #1;
    exp_rd_data = 16'h0000;
    check_reset_values("midreset");
    @(negedge clk);
    rst = 1'b0;
    idle(50);

    // Recovery after reset
    bus_words[0] = 16'hBEEF;
    run_txn(16'h0000, 0, 1'b0, 0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Time guard for the whole run.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
